pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: flush  input  1  synchronous discard of all held entries.
REQ-005 Port: in_valid  input  1  upstream offers in_data this cycle.
REQ-006 Port: in_ready  output  1  stage accepts in_data this cycle; registered.
REQ-007 Port: in_data  input  WIDTH  upstream payload.
REQ-008 Port: out_valid  output  1  out_data holds a valid entry.
REQ-009 Port: out_ready  input  1  downstream register enable/accept.
REQ-010 Port: out_data  output  WIDTH  payload to downstream register D input.
REQ-011 Port: count  output  2  occupancy, 0..2.

Function
REQ-012 Two storage slots SHALL exist: main (drives out_data) and skid (overflow).
REQ-013 States SHALL be EMPTY (0 entries), ONE (main valid), TWO (main+skid valid); count SHALL equal 0/1/2 respectively.
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; out_data SHALL be main slot contents.
REQ-016 in_ready SHALL be a flop output, 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-017 EMPTY + in_fire -> ONE, main <= in_data; latency in_fire to out_valid SHALL be 1 cycle.
REQ-018 ONE + in_fire + out_fire -> ONE, main <= in_data.
REQ-019 ONE + in_fire + !out_fire -> TWO, skid <= in_data, main unchanged.
REQ-020 ONE + !in_fire + out_fire -> EMPTY.
REQ-021 TWO + out_fire -> ONE, main <= skid; TWO + !out_fire -> TWO, both slots held.
REQ-022 While out_valid & !out_ready, out_data SHALL remain stable.
REQ-023 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush/reset.
REQ-024 Back-to-back streaming with out_ready=1 SHALL sustain one transfer per cycle.
REQ-025 flush=1 SHALL override all other inputs: next state EMPTY, count 0, in_ready 1; an in_fire in the flush cycle SHALL be discarded.
REQ-026 Slot contents not captured SHALL retain previous values (no spurious writes when !in_fire).

Reset
REQ-027 rst assertion SHALL immediately, without clk, force state EMPTY, out_valid 0, in_ready 0, count 0, main and skid to 0.
REQ-028 On first rising clk after rst deassertion, in_ready SHALL become 1; reset mid-transfer SHALL discard all held entries.

Verification
REQ-029 Reset: rst=1 mid-cycle with state TWO -> out_valid=0, in_ready=0, count=0 before next clk edge; first edge after release -> in_ready=1.
REQ-030 Stream: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the following three cycles, count stays 1.
REQ-031 Stall fill: out_ready=0, push 0xA,0xB -> count=2, in_ready=0, out_data=0xA stable; push 0xC held at in_valid=1 not accepted.
REQ-032 Drain: from REQ-031, out_ready=1 -> out_data 0xA then 0xB, in_ready=1 one cycle after first out_fire, then 0xC accepted and delivered third.
REQ-033 Flush: state TWO with in_valid=1, flush=1 one cycle -> next cycle count=0, out_valid=0, in_ready=1; no old or flushed-cycle data ever appears.
REQ-034 Random: random in_valid/out_ready/flush vs. scoreboard queue -> order preserved, no loss except flush, in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline skid stage.
// The main slot drives out_data. The skid slot catches the one extra word
// that upstream may push in the cycle before in_ready (a flop) drops.
// in_ready is computed from the next state only, so out_ready never reaches
// it through combinational logic.
//
// state   | meaning
// --------+------------------------------------------
// S_EMPTY | no entries held, out_valid low
// S_ONE   | main slot valid
// S_TWO   | main and skid valid, in_ready low
`timescale 1ns/1ps

module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_ready_nxt;
    logic             in_fire, out_fire;

    assign out_valid = (state != S_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Occupancy decoded from the state.
    always_comb begin
        count = 2'd0;
        case (state)
            S_ONE:   count = 2'd1;
            S_TWO:   count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Next-state and slot-capture logic; flush wins over everything.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            S_EMPTY: begin
                if (in_fire) begin
                    state_nxt = S_ONE;
                    main_nxt  = in_data;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_nxt = in_data;
                end else if (in_fire) begin
                    state_nxt = S_TWO;
                    skid_nxt  = in_data;
                end else if (out_fire) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_nxt = S_ONE;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            state_nxt = S_EMPTY;
            main_nxt  = main_q;
            skid_nxt  = skid_q;
        end
        in_ready_nxt = (state_nxt != S_TWO);
    end

    // State, slots and registered in_ready; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            main_q   <= main_nxt;
            skid_q   <= skid_nxt;
            in_ready <= in_ready_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus random
// traffic against a queue-based model of the stage's occupancy and ordering.
`timescale 1ns/1ps

module tb_pipe_skid_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ready;

    pipe_skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check_eq("in_ready", 32'(in_ready), 32'(m_ready));
        if (mq.size() != 0) check_eq("out_data", out_data, mq[0]);
    endtask

    // Apply one cycle of inputs (called just after a negedge), advance the
    // model by the stage's transfer rules, then check after the next edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic fl);
        logic m_in_fire, m_out_fire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        m_in_fire  = iv & m_ready;
        m_out_fire = (mq.size() != 0) & ordy;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire) mq.push_back(d);
        end
        m_ready = (mq.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic r0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // streaming at full rate
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        check_eq("stream0", out_data, 32'h11);
        check_eq("stream0_cnt", 32'(count), 32'd1);
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        check_eq("stream1", out_data, 32'h22);
        check_eq("stream1_cnt", 32'(count), 32'd1);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        check_eq("stream2", out_data, 32'h33);
        check_eq("stream2_cnt", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // stall fill, then drain with 0xC held at the input
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        check_eq("fill_cnt", 32'(count), 32'd2);
        check_eq("fill_ready", 32'(in_ready), 32'd0);
        check_eq("fill_data", out_data, 32'hA);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        check_eq("fill_hold_data", out_data, 32'hA);
        check_eq("fill_hold_cnt", 32'(count), 32'd2);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check_eq("drain_b", out_data, 32'hB);
        check_eq("drain_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check_eq("drain_c", out_data, 32'hC);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // flush from TWO and from ONE with an in_fire in the flush cycle
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b0, 1'b1);
        check_eq("flush2_cnt", 32'(count), 32'd0);
        check_eq("flush2_valid", 32'(out_valid), 32'd0);
        check_eq("flush2_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'h88, 1'b0, 1'b0);
        cycle(1'b1, 32'h99, 1'b1, 1'b1);
        check_eq("flush1_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("flush1_after", 32'(out_valid), 32'd0);

        // asynchronous reset while holding two entries
        cycle(1'b1, 32'hD1, 1'b0, 1'b0);
        cycle(1'b1, 32'hD2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_data", out_data, 32'd0);
        mq.delete();
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("arst_release_ready", 32'(in_ready), 32'd1);

        // random traffic; also probe that in_ready ignores out_ready
        for (int i = 0; i < 2000; i++) begin
            out_ready = 1'b0;
            #1 r0 = in_ready;
            out_ready = 1'b1;
            #1 check_eq("ready_indep", 32'(in_ready), 32'(r0));
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
